stream_packet_source: RTL and testbench
=======================================

STREAM_PACKET_SOURCE -- requirements
Module: stream_packet_source

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, meaning stream width in bytes; only 8 is supported.
REQ-002 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stream_out_data  output  64  Avalon-ST data; first byte is in [63:56].
- stream_out_empty  output  3  unused bytes in the eop beat; 0 on all other beats.
- stream_out_valid  output  1  beat valid.
- stream_out_startofpacket  output  1  first beat of a packet.
- stream_out_endofpacket  output  1  last beat of a packet.
- stream_out_ready  input  1  sink ready; readyLatency 0.
- csr_address  input  2  register select.
- csr_readdata  output  32  read data.
- csr_readdatavalid  output  1  read data valid.
- csr_read  input  1  read strobe.
- csr_write  input  1  write strobe.
- csr_waitrequest  output  1  access stall.
- csr_writedata  input  32  write data.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL implement a CSR map with fixed readLatency 1:
- addr0: bit0 enable (R/W); bit1 busy (RO).
- addr1: bits15:0 pkt_len in bytes (R/W, reset 64); a value of 0 is treated as 1.
- addr2: bits15:0 pkt_target (R/W, reset 0); 0 means continuous.
- addr3: pkt_sent (RO, 32-bit).
- Unused bits read 0.
REQ-005 Read accepted (csr_read & !csr_waitrequest) SHALL give csr_readdatavalid=1 with data exactly one cycle later; otherwise readdatavalid SHALL be 0.
REQ-006 SHALL assert csr_waitrequest combinationally while reset=1, or while csr_write=1 to addr1/addr2 and busy=1; reads and addr0 writes SHALL never stall.
REQ-007 SHALL implement the FSM IDLE, SEND:
- IDLE->SEND on the cycle after enable becomes 1.
- busy=1 in SEND.
REQ-008 Rising edge of enable (0->1 write) SHALL clear pkt_sent to 0.
REQ-009 In SEND, SHALL hold stream_out_valid=1 continuously and present back-to-back beats with no idle gaps.
REQ-010 Beat transfer SHALL occur when valid & ready; data/empty/sop/eop/valid SHALL stay stable while valid & !ready.
REQ-011 Beat count per packet SHALL be ceil(L/8), L = effective pkt_len.
- sop SHALL be 1 on beat 0 only.
- eop SHALL be 1 on the last beat only.
- Single-beat packets SHALL have sop=eop=1.
REQ-012 eop-beat stream_out_empty SHALL be (8 - L mod 8) mod 8; unused byte lanes SHALL be 0.
REQ-013 Byte k of a packet (k=0..L-1) SHALL be (seed + k) mod 256, seed = pkt_sent[7:0] at packet start; byte k is placed in lane k mod 8, with lane 0 = [63:56].
REQ-014 On eop transfer, SHALL increment pkt_sent, wrapping modulo 2^32.
REQ-015 After eop transfer, SHALL go to IDLE (deasserting valid next cycle) if either:
- pkt_target != 0 and the new pkt_sent == pkt_target, in which case enable SHALL be cleared to 0 by hardware; or
- enable == 0.
Otherwise SHALL start the next packet on the following beat.
REQ-016 Clearing enable mid-packet SHALL NOT truncate the packet; the current packet completes.
REQ-017 pkt_len/pkt_target SHALL be sampled at packet start; a simultaneous CSR write and sop beat SHALL affect only the following packet.
REQ-018 When a software addr0 write coincides with the hardware enable-clear of REQ-015, the software write SHALL win.

Reset
REQ-019 While reset=1, SHALL set:
- stream_out_valid/startofpacket/endofpacket/empty/data = 0.
- csr_readdatavalid = 0, csr_readdata = 0.
- enable = 0, pkt_len = 64, pkt_target = 0, pkt_sent = 0.
- FSM = IDLE.
REQ-020 Reset asserted mid-packet SHALL drop stream_out_valid asynchronously; no partial packet SHALL resume after reset.

Verification
REQ-021 len=16, target=1, enable=1, ready=1 -> exactly 2 beats:
- beat 0: sop=1, data 0x0001020304050607.
- beat 1: eop=1, empty=0, data 0x08090A0B0C0D0E0F.
- then valid=0, busy=0, enable=0, addr3 reads 1.
REQ-022 len=13, target=2 -> per packet: 2 beats, eop empty=3.
- packet 0 beat 1 data 0x08090A0B0C000000.
- packet 1 beat 0 data 0x0102030405060708 (seed 1).
REQ-023 len=0, target=1 -> single beat with sop=eop=1, empty=7, data 0x0000000000000000.
REQ-024 ready held 0 for 3 cycles mid-packet -> all stream outputs unchanged over those cycles; no beat lost or duplicated.
REQ-025 Continuous mode (target=0), enable cleared during beat 1 of a 24-byte packet -> packet completes through eop, then no further sop.
REQ-026 CSR write to addr1 while busy -> waitrequest=1 until IDLE, then write accepted; reset pulse mid-packet -> valid=0 immediately, addr1 reads 64 afterwards.

Source files
------------

// File: rtl/stream_packet_source.sv
// Avalon-ST packet generator with a small CSR block.
// Packets carry an incrementing byte pattern seeded from the sent counter.
module stream_packet_source #(
   parameter int DATA_BYTES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic [8*DATA_BYTES-1:0] stream_out_data,
   output logic [2:0]              stream_out_empty,
   output logic                    stream_out_valid,
   output logic                    stream_out_startofpacket,
   output logic                    stream_out_endofpacket,
   input  logic                    stream_out_ready,
   input  logic [1:0]              csr_address,
   output logic [31:0]             csr_readdata,
   output logic                    csr_readdatavalid,
   input  logic                    csr_read,
   input  logic                    csr_write,
   output logic                    csr_waitrequest,
   input  logic [31:0]             csr_writedata
);

   localparam int W = 8 * DATA_BYTES;

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q, state_d;
   logic        enable_q, enable_d;
   logic [15:0] pkt_len_q, pkt_len_d;
   logic [15:0] pkt_target_q, pkt_target_d;
   logic [31:0] pkt_sent_q, pkt_sent_d;

   logic [7:0]  cur_seed_q, cur_seed_d;
   logic [15:0] cur_len_q, cur_len_d;
   logic [12:0] cur_last_q, cur_last_d;
   logic [2:0]  cur_empty_q, cur_empty_d;
   logic [15:0] cur_target_q, cur_target_d;
   logic [12:0] beat_q, beat_d;

   logic [W-1:0] data_q, data_d;
   logic [2:0]   empty_q, empty_d;
   logic         sop_q, sop_d;
   logic         eop_q, eop_d;
   logic         valid_q, valid_d;

   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;

   logic        busy;
   logic        xfer;
   logic        wr_ok;
   logic        rd_ok;
   logic [15:0] eff_len;
   logic [12:0] eff_last;
   logic [2:0]  eff_empty;
   logic        ld_new;
   logic        ld_next;
   logic        hit;
   logic [7:0]  new_seed;
   logic        unused_wdata;

   function automatic logic [W-1:0] beat_data(
      input logic [7:0]  seed,
      input logic [12:0] b,
      input logic [15:0] len
   );
      logic [W-1:0] d;
      logic [16:0]  k;
      d = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         k = {1'b0, b, 3'(i)};
         if (k < {1'b0, len})
            d[W-1-8*i -: 8] = seed + k[7:0];
      end
      return d;
   endfunction

   assign busy = (state_q == SEND);
   assign xfer = valid_q & stream_out_ready;

   assign csr_waitrequest = reset |
      (csr_write & busy &
       ((csr_address == 2'd1) | (csr_address == 2'd2)));

   assign wr_ok = csr_write & ~csr_waitrequest;
   assign rd_ok = csr_read & ~csr_waitrequest;

   // A zero length still produces one byte.
   assign eff_len   = (pkt_len_q == 16'd0) ? 16'd1 : pkt_len_q;
   assign eff_last  = 13'((eff_len - 16'd1) >> 3);
   assign eff_empty = 3'd0 - eff_len[2:0];

   assign unused_wdata = ^csr_writedata[31:16];

   always_comb begin
      state_d      = state_q;
      enable_d     = enable_q;
      pkt_len_d    = pkt_len_q;
      pkt_target_d = pkt_target_q;
      pkt_sent_d   = pkt_sent_q;
      cur_seed_d   = cur_seed_q;
      cur_len_d    = cur_len_q;
      cur_last_d   = cur_last_q;
      cur_empty_d  = cur_empty_q;
      cur_target_d = cur_target_q;
      beat_d       = beat_q;
      data_d       = data_q;
      empty_d      = empty_q;
      sop_d        = sop_q;
      eop_d        = eop_q;
      valid_d      = valid_q;
      rdata_d      = 32'd0;
      rvalid_d     = 1'b0;
      ld_new       = 1'b0;
      ld_next      = 1'b0;
      hit          = 1'b0;
      new_seed     = 8'd0;

      unique case (state_q)
         IDLE: begin
            if (enable_q) begin
               state_d  = SEND;
               ld_new   = 1'b1;
               new_seed = pkt_sent_q[7:0];
            end
         end
         SEND: begin
            if (xfer) begin
               if (!eop_q) begin
                  ld_next = 1'b1;
               end else begin
                  pkt_sent_d = pkt_sent_q + 32'd1;
                  hit = (cur_target_q != 16'd0) &&
                        (pkt_sent_d == {16'd0, cur_target_q});
                  if (hit || !enable_q) begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                     sop_d   = 1'b0;
                     eop_d   = 1'b0;
                     empty_d = 3'd0;
                     data_d  = '0;
                     if (hit)
                        enable_d = 1'b0;
                  end else begin
                     ld_new   = 1'b1;
                     new_seed = pkt_sent_d[7:0];
                  end
               end
            end
         end
      endcase

      // Length and target are latched only when a packet begins.
      if (ld_new) begin
         cur_seed_d   = new_seed;
         cur_len_d    = eff_len;
         cur_last_d   = eff_last;
         cur_empty_d  = eff_empty;
         cur_target_d = pkt_target_q;
         beat_d       = 13'd0;
      end else if (ld_next) begin
         beat_d = beat_q + 13'd1;
      end

      if (ld_new || ld_next) begin
         valid_d = 1'b1;
         data_d  = beat_data(cur_seed_d, beat_d, cur_len_d);
         sop_d   = (beat_d == 13'd0);
         eop_d   = (beat_d == cur_last_d);
         empty_d = eop_d ? cur_empty_d : 3'd0;
      end

      // Software enable write overrides the hardware clear.
      if (wr_ok) begin
         unique case (csr_address)
            2'd0: begin
               enable_d = csr_writedata[0];
               if (csr_writedata[0] && !enable_q)
                  pkt_sent_d = 32'd0;
            end
            2'd1: pkt_len_d    = csr_writedata[15:0];
            2'd2: pkt_target_d = csr_writedata[15:0];
            2'd3: ;
         endcase
      end

      if (rd_ok) begin
         rvalid_d = 1'b1;
         unique case (csr_address)
            2'd0: rdata_d = {30'd0, busy, enable_q};
            2'd1: rdata_d = {16'd0, pkt_len_q};
            2'd2: rdata_d = {16'd0, pkt_target_q};
            2'd3: rdata_d = pkt_sent_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         enable_q     <= 1'b0;
         pkt_len_q    <= 16'd64;
         pkt_target_q <= 16'd0;
         pkt_sent_q   <= 32'd0;
         cur_seed_q   <= 8'd0;
         cur_len_q    <= 16'd0;
         cur_last_q   <= 13'd0;
         cur_empty_q  <= 3'd0;
         cur_target_q <= 16'd0;
         beat_q       <= 13'd0;
         data_q       <= '0;
         empty_q      <= 3'd0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         valid_q      <= 1'b0;
         rdata_q      <= 32'd0;
         rvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         pkt_len_q    <= pkt_len_d;
         pkt_target_q <= pkt_target_d;
         pkt_sent_q   <= pkt_sent_d;
         cur_seed_q   <= cur_seed_d;
         cur_len_q    <= cur_len_d;
         cur_last_q   <= cur_last_d;
         cur_empty_q  <= cur_empty_d;
         cur_target_q <= cur_target_d;
         beat_q       <= beat_d;
         data_q       <= data_d;
         empty_q      <= empty_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         valid_q      <= valid_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
      end
   end

   assign stream_out_data          = data_q;
   assign stream_out_empty         = empty_q;
   assign stream_out_valid         = valid_q;
   assign stream_out_startofpacket = sop_q;
   assign stream_out_endofpacket   = eop_q;
   assign csr_readdata             = rdata_q;
   assign csr_readdatavalid        = rvalid_q;

endmodule

// File: tb/tb_stream_packet_source.sv
// Scoreboard bench for stream_packet_source: expected beats and CSR
// read data are queued by the stimulus and popped by a negedge monitor.
module tb_stream_packet_source;

   logic        clk;
   logic        reset;
   logic [63:0] data;
   logic [2:0]  empty;
   logic        valid;
   logic        sop;
   logic        eop;
   logic        ready;
   logic [1:0]  addr;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rd;
   logic        wr;
   logic        wait_r;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;

   logic [68:0] bq[$];
   logic [31:0] rq[$];

   logic        prev_stall = 1'b0;
   logic [68:0] prev_beat;

   stream_packet_source #(.DATA_BYTES(8)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .stream_out_data          (data),
      .stream_out_empty         (empty),
      .stream_out_valid         (valid),
      .stream_out_startofpacket (sop),
      .stream_out_endofpacket   (eop),
      .stream_out_ready         (ready),
      .csr_address              (addr),
      .csr_readdata             (rdata),
      .csr_readdatavalid        (rvalid),
      .csr_read                 (rd),
      .csr_write                (wr),
      .csr_waitrequest          (wait_r),
      .csr_writedata            (wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [68:0] act,
                      input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic exp_beat(input logic [63:0] d, input logic [2:0] e,
                           input logic s, input logic p);
      bq.push_back({d, e, s, p});
   endtask

   // Monitor: beats on valid&ready, read data on readdatavalid,
   // and output stability across stalled cycles.
   always @(negedge clk) begin
      if (valid && ready && !reset) begin
         if (bq.size() == 0) begin
            chk("unexpected_beat", {data, empty, sop, eop}, 69'd0);
         end else begin
            chk("beat", {data, empty, sop, eop}, bq.pop_front());
         end
      end
      if (rvalid) begin
         if (rq.size() == 0) begin
            chk("unexpected_rdv", {37'd0, rdata}, 69'd0);
         end else begin
            chk("csr_rdata", {37'd0, rdata}, {37'd0, rq.pop_front()});
         end
      end
      if (prev_stall && !reset) begin
         chk("stall_hold", {valid, data, empty, sop, eop},
             {1'b1, prev_beat});
      end
      prev_stall = valid && !ready && !reset;
      prev_beat  = {data, empty, sop, eop};
   end

   task automatic csr_wr_n(input logic [1:0] a, input logic [31:0] d,
                           output int n);
      n     = 0;
      wr    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      while (wait_r && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000)
         chk("wr_timeout", 69'(n), 69'd0);
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      int n;
      csr_wr_n(a, d, n);
   endtask

   task automatic csr_rd(input logic [1:0] a, input logic [31:0] e);
      rd   = 1'b1;
      addr = a;
      rq.push_back(e);
      @(posedge clk);
      #1;
      rd = 1'b0;
   endtask

   task automatic wait_sop_xfer();
      int n = 0;
      @(negedge clk);
      while (!(valid && ready && sop) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500)
         chk("sop_timeout", 69'(n), 69'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((bq.size() != 0 || valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000)
         chk("idle_timeout", 69'(n), 69'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      ready = 1'b1;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;

      // Reset state
      @(negedge clk);
      chk("rst_stream", {valid, sop, eop, empty, data}, 69'd0);
      chk("rst_csr", {rvalid, rdata}, 69'd0);
      chk("rst_wait", 69'(wait_r), 69'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      csr_rd(2'd0, 32'd0);
      csr_rd(2'd1, 32'd64);
      csr_rd(2'd2, 32'd0);
      csr_rd(2'd3, 32'd0);

      // 16 bytes, one packet
      csr_wr(2'd1, 32'd16);
      csr_wr(2'd2, 32'd1);
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h08090A0B0C0D0E0F, 3'd0, 1'b0, 1'b1);
      csr_wr(2'd0, 32'd1);
      wait_idle();
      chk("t1_valid_low", 69'(valid), 69'd0);
      csr_rd(2'd0, 32'd0);
      csr_rd(2'd3, 32'd1);

      // 13 bytes, two packets
      csr_wr(2'd1, 32'd13);
      csr_wr(2'd2, 32'd2);
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h08090A0B0C000000, 3'd3, 1'b0, 1'b1);
      exp_beat(64'h0102030405060708, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h090A0B0C0D000000, 3'd3, 1'b0, 1'b1);
      csr_wr(2'd0, 32'd1);
      wait_idle();
      csr_rd(2'd3, 32'd2);

      // zero length behaves as one byte
      csr_wr(2'd1, 32'd0);
      csr_wr(2'd2, 32'd1);
      exp_beat(64'h0000000000000000, 3'd7, 1'b1, 1'b1);
      csr_wr(2'd0, 32'd1);
      wait_idle();
      csr_rd(2'd3, 32'd1);

      // backpressure for three cycles on beat 1
      csr_wr(2'd1, 32'd24);
      csr_wr(2'd2, 32'd1);
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h08090A0B0C0D0E0F, 3'd0, 1'b0, 1'b0);
      exp_beat(64'h1011121314151617, 3'd0, 1'b0, 1'b1);
      csr_wr(2'd0, 32'd1);
      wait_sop_xfer();
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ready = 1'b1;
      wait_idle();

      // continuous mode, enable cleared during beat 1
      csr_wr(2'd2, 32'd0);
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h08090A0B0C0D0E0F, 3'd0, 1'b0, 1'b0);
      exp_beat(64'h1011121314151617, 3'd0, 1'b0, 1'b1);
      csr_wr(2'd0, 32'd1);
      wait_sop_xfer();
      csr_wr(2'd0, 32'd0);
      wait_idle();
      repeat (10) @(posedge clk);
      #1;
      csr_rd(2'd3, 32'd1);
      csr_rd(2'd0, 32'd0);

      // addr1 write stalls while busy
      csr_wr(2'd1, 32'd16);
      csr_wr(2'd2, 32'd1);
      ready = 1'b0;
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      exp_beat(64'h08090A0B0C0D0E0F, 3'd0, 1'b0, 1'b1);
      csr_wr(2'd0, 32'd1);
      @(posedge clk);
      #1;
      fork
         begin
            repeat (3) @(negedge clk);
            chk("busy_wait", 69'(wait_r), 69'd1);
            @(posedge clk);
            #1;
            ready = 1'b1;
         end
         begin
            csr_wr_n(2'd1, 32'd8, n);
         end
      join
      chk("wr_stalled", 69'(n != 0), 69'd1);
      wait_idle();
      csr_rd(2'd1, 32'd8);
      csr_rd(2'd3, 32'd1);

      // reset mid-packet
      csr_wr(2'd1, 32'd32);
      csr_wr(2'd2, 32'd0);
      exp_beat(64'h0001020304050607, 3'd0, 1'b1, 1'b0);
      csr_wr(2'd0, 32'd1);
      wait_sop_xfer();
      ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async_valid", 69'(valid), 69'd0);
      chk("rst_async_wait", 69'(wait_r), 69'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ready = 1'b1;
      csr_rd(2'd1, 32'd64);
      csr_rd(2'd0, 32'd0);
      csr_rd(2'd3, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("no_resume", 69'(valid), 69'd0);

      chk("beats_left", 69'(bq.size()), 69'd0);
      chk("reads_left", 69'(rq.size()), 69'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
